csi_packet_sequencer: RTL
=========================

// Module: csi_packet_sequencer
// PURPOSE
// - Sequences each CSI-2 HS burst from the lane merger into header, payload and checksum phases.
// - Sits between the lane merger and the packet-handler FSM; it generates the header-select and valid qualifiers that FSM consumes.
// - Tracks the word count so payload is framed exactly, including odd word counts.
// - One packet per HS burst; trailing filler bytes after the checksum are discarded.
// PARAMETERS
// - DATA_WIDTH   16  merged lane width in bits; 2 bytes/cycle, byte0 = [7:0] received first. Only 16 supported.
// - WC_WIDTH     16  word-count / remaining-byte counter width.
// PORTS
// - rxbyteclkhs  in   1   byte clock
// - reset        in   1   synchronous, active-high
// - enable       in   1   accept new bursts when high
// - in_data      in   16  merged lane bytes
// - in_valid     in   1   high for the contiguous duration of an HS burst; low = EoT
// - ph_stream    out  24  {WC_MSB, WC_LSB, DI} of the current packet
// - ph_ecc       out  8   received ECC byte, for the downstream ECC checker
// - ph_select    out  1   1-cycle pulse: ph_stream/ph_ecc are valid this cycle
// - pl_data      out  16  payload bytes
// - pl_keep      out  2   byte enables for pl_data; 2'b11 full word, 2'b01 low byte only
// - pl_valid     out  1   pl_data is valid this cycle
// - crc_rx       out  16  received packet checksum {MSB, LSB}
// - crc_valid    out  1   1-cycle pulse: crc_rx is valid
// - pkt_error    out  1   1-cycle pulse: burst ended before the packet was complete
// - busy         out  1   high in any state other than IDLE
// BEHAVIOUR
// - Reset: state = IDLE. All outputs 0. ph_stream, ph_ecc and crc_rx are cleared to 0.
// - All outputs are registered. Each output appears 1 cycle after the in_data word that produced it.
// - IDLE
//   - in_valid && enable: latch DI = byte0, WC_LSB = byte1; go to PH1.
//   - in_valid && !enable: go to WAIT_EOT, ignoring the whole burst.
// - PH1: takes the next in_valid word.
//   - WC_MSB = byte0, ECC = byte1. Emit ph_stream, ph_ecc and ph_select.
//   - Short packet (DI[5:0] <= 6'h0F): go to WAIT_EOT.
//   - Long packet with WC == 0: go to CRC.
//   - Otherwise: rem = WC; go to PAYLOAD.
// - PAYLOAD: per in_valid word.
//   - rem > 2: pl_valid = 1, keep = 11, rem -= 2.
//   - rem == 2: pl_valid = 1, keep = 11; go to CRC.
//   - rem == 1: pl_valid = 1, keep = 01; crc LSB = byte1; go to CRC_HI.
// - CRC: crc_rx = {byte1, byte0}; pulse crc_valid; go to WAIT_EOT.
// - CRC_HI: crc_rx = {byte0, latched LSB}; pulse crc_valid; go to WAIT_EOT.
// - WAIT_EOT: ignore in_data while in_valid is high. Go to IDLE on the first cycle in_valid == 0.
// - Early EoT: in_valid == 0 in PH1, PAYLOAD, CRC or CRC_HI.
//   - Pulse pkt_error, go to IDLE.
//   - Emit no ph_select, pl_valid or crc_valid for that cycle.
// - enable is sampled only in IDLE. Deasserting it mid-packet lets the packet complete.
// - Reset asserted mid-packet: go to IDLE at once; pending pulses are dropped.
// - rem arithmetic is unsigned WC_WIDTH and never underflows. The WC = 65535 maximum is legal.
// - busy = (state != IDLE); it is registered with the state.
// TESTING
// - Short packet burst {DI=00, WC=0001, ECC=xx}, then 2 filler words:
//   -> one ph_select with ph_stream = 24'h000100; no pl_valid or crc_valid; busy drops 1 cycle after in_valid drops.
// - Long RAW10 packet DI=2B, WC=0006, payload 11 22 33 44 55 66, CRC AB CD:
//   -> 3 pl_valid cycles with keep = 11 and data 2211, 4433, 6655; crc_rx = 16'hCDAB.
// - Odd WC=0003, payload 11 22 33, then bytes AB CD:
//   -> pl data 2211 keep 11, then xx33 keep 01; crc_valid with crc_rx = 16'hCDAB.
// - in_valid drops after 2 of 3 payload words (WC=0006) -> pkt_error pulse, no crc_valid, state returns to IDLE.
// - enable = 0 during a whole burst -> no output pulses. Deassert enable in PH1 -> packet completes normally.
// - Reset asserted during PAYLOAD -> all outputs 0 next cycle; the next burst is decoded correctly from IDLE.

Source files
------------

// File: rtl/csi_packet_sequencer_if.sv
// Bus between the lane merger, the packet sequencer and the packet-handler FSM.
// master = burst source / result consumer, slave = the sequencer itself.
interface csi_packet_sequencer_if #(
  parameter int DATA_WIDTH = 16
);
  logic [DATA_WIDTH-1:0]   in_data;
  logic                    in_valid;
  logic [23:0]             ph_stream;
  logic [7:0]              ph_ecc;
  logic                    ph_select;
  logic [DATA_WIDTH-1:0]   pl_data;
  logic [DATA_WIDTH/8-1:0] pl_keep;
  logic                    pl_valid;
  logic [15:0]             crc_rx;
  logic                    crc_valid;
  logic                    pkt_error;
  logic                    busy;

  modport master (
    output in_data, in_valid,
    input  ph_stream, ph_ecc, ph_select, pl_data, pl_keep, pl_valid,
           crc_rx, crc_valid, pkt_error, busy
  );

  modport slave (
    input  in_data, in_valid,
    output ph_stream, ph_ecc, ph_select, pl_data, pl_keep, pl_valid,
           crc_rx, crc_valid, pkt_error, busy
  );
endinterface

// File: rtl/csi_packet_sequencer.sv
// Splits one CSI-2 HS burst into packet header, payload and checksum phases.
// Every output is registered and reflects the input word of the previous cycle.
module csi_packet_sequencer #(
  parameter int DATA_WIDTH = 16,
  parameter int WC_WIDTH   = 16
) (
  input  logic rxbyteclkhs,
  input  logic reset,
  input  logic enable,
  csi_packet_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE, PH1, PAYLOAD, CRC, CRC_HI, WAIT_EOT
  } state_t;

  state_t state, state_d;

  logic [DATA_WIDTH-1:0] word;
  logic [7:0]            byte0, byte1;
  logic [7:0]            di, di_d, wc_lsb, wc_lsb_d, crc_lsb, crc_lsb_d;
  logic [WC_WIDTH-1:0]   rem, rem_d, wc;

  logic [23:0] ph_stream_d;
  logic [7:0]  ph_ecc_d;
  logic        ph_select_d, pl_valid_d, crc_valid_d, pkt_error_d, busy_d;
  logic [DATA_WIDTH-1:0] pl_data_d;
  logic [1:0]  pl_keep_d;
  logic [15:0] crc_rx_d;

  assign word  = bus.in_data;
  assign byte0 = word[7:0];
  assign byte1 = word[15:8];
  // Full word count once the MSB arrives in PH1.
  assign wc    = WC_WIDTH'({byte0, wc_lsb});

  // Next-state and next-output decode; pulses default low, held fields keep their value.
  always_comb begin
    state_d     = state;
    di_d        = di;
    wc_lsb_d    = wc_lsb;
    rem_d       = rem;
    crc_lsb_d   = crc_lsb;
    ph_stream_d = bus.ph_stream;
    ph_ecc_d    = bus.ph_ecc;
    ph_select_d = 1'b0;
    pl_data_d   = bus.pl_data;
    pl_keep_d   = 2'b00;
    pl_valid_d  = 1'b0;
    crc_rx_d    = bus.crc_rx;
    crc_valid_d = 1'b0;
    pkt_error_d = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.in_valid) begin
          if (enable) begin
            di_d     = byte0;
            wc_lsb_d = byte1;
            state_d  = PH1;
          end else begin
            state_d  = WAIT_EOT;
          end
        end
      end
      PH1: begin
        if (!bus.in_valid) begin
          pkt_error_d = 1'b1;
          state_d     = IDLE;
        end else begin
          ph_stream_d = {byte0, wc_lsb, di};
          ph_ecc_d    = byte1;
          ph_select_d = 1'b1;
          if (di[5:0] <= 6'h0F)  state_d = WAIT_EOT;
          else if (wc == '0)     state_d = CRC;
          else begin
            rem_d   = wc;
            state_d = PAYLOAD;
          end
        end
      end
      PAYLOAD: begin
        if (!bus.in_valid) begin
          pkt_error_d = 1'b1;
          state_d     = IDLE;
        end else begin
          pl_valid_d = 1'b1;
          pl_data_d  = word;
          if (rem > WC_WIDTH'(2)) begin
            pl_keep_d = 2'b11;
            rem_d     = rem - WC_WIDTH'(2);
          end else if (rem == WC_WIDTH'(2)) begin
            pl_keep_d = 2'b11;
            state_d   = CRC;
          end else begin
            // Odd word count: the high byte is already the checksum LSB.
            pl_keep_d = 2'b01;
            crc_lsb_d = byte1;
            state_d   = CRC_HI;
          end
        end
      end
      CRC: begin
        if (!bus.in_valid) begin
          pkt_error_d = 1'b1;
          state_d     = IDLE;
        end else begin
          crc_rx_d    = {byte1, byte0};
          crc_valid_d = 1'b1;
          state_d     = WAIT_EOT;
        end
      end
      CRC_HI: begin
        if (!bus.in_valid) begin
          pkt_error_d = 1'b1;
          state_d     = IDLE;
        end else begin
          crc_rx_d    = {byte0, crc_lsb};
          crc_valid_d = 1'b1;
          state_d     = WAIT_EOT;
        end
      end
      WAIT_EOT: begin
        if (!bus.in_valid) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // State, working registers and registered outputs; reset drops any pending pulse.
  always_ff @(posedge rxbyteclkhs) begin
    if (reset) begin
      state         <= IDLE;
      di            <= '0;
      wc_lsb        <= '0;
      rem           <= '0;
      crc_lsb       <= '0;
      bus.ph_stream <= '0;
      bus.ph_ecc    <= '0;
      bus.ph_select <= 1'b0;
      bus.pl_data   <= '0;
      bus.pl_keep   <= '0;
      bus.pl_valid  <= 1'b0;
      bus.crc_rx    <= '0;
      bus.crc_valid <= 1'b0;
      bus.pkt_error <= 1'b0;
      bus.busy      <= 1'b0;
    end else begin
      state         <= state_d;
      di            <= di_d;
      wc_lsb        <= wc_lsb_d;
      rem           <= rem_d;
      crc_lsb       <= crc_lsb_d;
      bus.ph_stream <= ph_stream_d;
      bus.ph_ecc    <= ph_ecc_d;
      bus.ph_select <= ph_select_d;
      bus.pl_data   <= pl_data_d;
      bus.pl_keep   <= pl_keep_d;
      bus.pl_valid  <= pl_valid_d;
      bus.crc_rx    <= crc_rx_d;
      bus.crc_valid <= crc_valid_d;
      bus.pkt_error <= pkt_error_d;
      bus.busy      <= busy_d;
    end
  end

endmodule
